// File: rtl/vga_timing_gen.sv
// VGA timing and pattern generator: pixel-strobe divider, programmable h/v counters,
// coordinate-based pixel requests and a one-pixel registered output stage.
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 29,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int NUM_BARS = 5,
  parameter int GRID     = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          mode,
  input  logic [NUM_BARS-1:0] highlight,
  input  logic [23:0]         pixel_in,
  output logic                pix_req,
  output logic [11:0]         pix_x,
  output logic [11:0]         pix_y,
  output logic                h_sync,
  output logic                v_sync,
  output logic                vga_blank,
  output logic                vga_clock,
  output logic [7:0]          red,
  output logic [7:0]          green,
  output logic [7:0]          blue,
  output logic                frame_start
);

  localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_ACTIVE + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int BAR_W    = H_ACTIVE / NUM_BARS;
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic             pe_q, pe_d;
  logic             vclk_q, vclk_d;
  logic [11:0]      h_q, h_d, v_q, v_d;
  logic [11:0]      bar_col_q, bar_col_d;
  logic [4:0]       bar_idx_q, bar_idx_d;
  logic [11:0]      px_q, px_d, py_q, py_d;
  logic [1:0]       mode_q, mode_d, mode_eff;
  logic             hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
  logic [23:0]      rgb_q, rgb_d;
  logic             active, h_last, v_last;
  logic [15:0]      hl_ext;

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return 24'hFF0000;
      3'd1:    return 24'hFFA500;
      3'd2:    return 24'hFFFF00;
      3'd3:    return 24'h00FF00;
      3'd4:    return 24'h0000FF;
      3'd5:    return 24'h00FFFF;
      3'd6:    return 24'hFF00FF;
      default: return 24'h808080;
    endcase
  endfunction

  // pe is registered from the next divider value so it stays low while reset is held
  always_comb begin
    div_d  = (pe_q || CLK_DIV == 1) ? '0 : div_q + 1'b1;
    pe_d   = (div_d == DIV_W'(CLK_DIV - 1));
    vclk_d = (div_d >= DIV_W'(CLK_DIV / 2));
  end

  assign h_last      = (h_q == 12'(H_TOTAL - 1));
  assign v_last      = (v_q == 12'(V_TOTAL - 1));
  assign active      = (h_q < 12'(H_ACTIVE)) && (v_q < 12'(V_ACTIVE));
  assign frame_start = pe_q && (h_q == '0) && (v_q == '0);
  assign pix_req     = pe_q && active;
  assign pix_x       = pix_req ? h_q : px_q;
  assign pix_y       = pix_req ? v_q : py_q;
  assign mode_eff    = frame_start ? mode : mode_q;
  assign hl_ext      = 16'(highlight);

  always_comb begin
    h_d       = h_q;
    v_d       = v_q;
    bar_col_d = bar_col_q;
    bar_idx_d = bar_idx_q;
    px_d      = pix_x;
    py_d      = pix_y;
    mode_d    = mode_eff;
    if (pe_q) begin
      h_d = h_last ? '0 : h_q + 1'b1;
      if (h_last) v_d = v_last ? '0 : v_q + 1'b1;
      if (h_last) begin
        bar_col_d = '0;
        bar_idx_d = '0;
      end else if (bar_col_q == 12'(BAR_W - 1)) begin
        bar_col_d = '0;
        if (bar_idx_q < 5'(NUM_BARS)) bar_idx_d = bar_idx_q + 1'b1;
      end else begin
        bar_col_d = bar_col_q + 1'b1;
      end
    end
  end

  always_comb begin
    hs_d    = ((h_q >= 12'(HS_START)) && (h_q < 12'(HS_END))) ? HS_POL : ~HS_POL;
    vs_d    = ((v_q >= 12'(VS_START)) && (v_q < 12'(VS_END))) ? VS_POL : ~VS_POL;
    blank_d = active;
    rgb_d   = '0;
    if (active) begin
      case (mode_eff)
        2'd0: rgb_d = pixel_in;
        2'd1: begin
          if (bar_idx_q < 5'(NUM_BARS))
            rgb_d = hl_ext[bar_idx_q[3:0]] ? 24'hFFFFFF : bar_colour(bar_idx_q[2:0]);
        end
        2'd2: begin
          if (((h_q & 12'(GRID - 1)) == '0) || ((v_q & 12'(GRID - 1)) == '0) ||
              (h_q == 12'(H_ACTIVE - 1)) || (v_q == 12'(V_ACTIVE - 1)))
            rgb_d = 24'hFFFFFF;
        end
        default: rgb_d = '0;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_q     <= '0;
      pe_q      <= 1'b0;
      vclk_q    <= 1'b0;
      h_q       <= '0;
      v_q       <= '0;
      bar_col_q <= '0;
      bar_idx_q <= '0;
      px_q      <= '0;
      py_q      <= '0;
      mode_q    <= '0;
      hs_q      <= ~HS_POL;
      vs_q      <= ~VS_POL;
      blank_q   <= 1'b0;
      rgb_q     <= '0;
    end else begin
      div_q     <= div_d;
      pe_q      <= pe_d;
      vclk_q    <= vclk_d;
      h_q       <= h_d;
      v_q       <= v_d;
      bar_col_q <= bar_col_d;
      bar_idx_q <= bar_idx_d;
      px_q      <= px_d;
      py_q      <= py_d;
      mode_q    <= mode_d;
      if (pe_q) begin
        hs_q    <= hs_d;
        vs_q    <= vs_d;
        blank_q <= blank_d;
        rgb_q   <= rgb_d;
      end
    end
  end

  assign h_sync            = hs_q;
  assign v_sync            = vs_q;
  assign vga_blank         = blank_q;
  assign vga_clock         = vclk_q;
  assign {red, green, blue} = rgb_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a reduced raster: an independent position
// model pushes per-pixel expectations that are popped once the output stage updates.
module tb_vga_timing_gen;

  localparam int CD = 2;
  localparam int HA = 20, HF = 2, HSW = 3, HB = 2;
  localparam int VA = 8,  VF = 1, VSW = 2, VB = 1;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam int NB = 3;
  localparam int GR = 4;
  localparam int BW = HA / NB;
  localparam int LIMIT = 5000;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    mode;
  logic [NB-1:0] highlight;
  logic [23:0]   pixel_in;
  logic          pix_req, h_sync, v_sync, vga_blank, vga_clock, frame_start;
  logic [11:0]   pix_x, pix_y;
  logic [7:0]    red, green, blue;

  int n_chk  = 0;
  int n_fail = 0;

  vga_timing_gen #(
    .CLK_DIV(CD), .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .NUM_BARS(NB), .GRID(GR)
  ) dut (
    .clock(clk), .reset(rst), .mode(mode), .highlight(highlight), .pixel_in(pixel_in),
    .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y), .h_sync(h_sync), .v_sync(v_sync),
    .vga_blank(vga_blank), .vga_clock(vga_clock), .red(red), .green(green), .blue(blue),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Upstream source answers each request with a coordinate-tagged pixel
  assign pixel_in = {pix_x[7:0], pix_y[7:0], 8'h5A};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] palette(input int i);
    case (i % 8)
      0: return 24'hFF0000;
      1: return 24'hFFA500;
      2: return 24'hFFFF00;
      3: return 24'h00FF00;
      4: return 24'h0000FF;
      5: return 24'h00FFFF;
      6: return 24'hFF00FF;
      default: return 24'h808080;
    endcase
  endfunction

  function automatic logic [23:0] exp_rgb(input logic [1:0] m, input int h, input int v,
                                          input logic [NB-1:0] hl);
    int b;
    if (!(h < HA && v < VA)) return 24'h0;
    case (m)
      2'd0: return {8'(h), 8'(v), 8'h5A};
      2'd1: begin
        b = h / BW;
        if (b >= NB) return 24'h0;
        if (hl[b]) return 24'hFFFFFF;
        return palette(b);
      end
      2'd2: begin
        if ((h % GR) == 0 || (v % GR) == 0 || h == HA - 1 || v == VA - 1) return 24'hFFFFFF;
        return 24'h0;
      end
      default: return 24'h0;
    endcase
  endfunction

  // model state: counter-stage position, clocks since reset release, latched mode
  int         k = 0, mh = 0, mv = 0, frames = 0, req_cnt = 0;
  bit         full_frame = 0;
  logic [1:0] mlat = 2'd0;
  logic [26:0] exp_q[$];

  always @(negedge clk) begin
    logic [26:0] e;
    logic        act, hs_e, vs_e;
    if (rst) begin
      k = 0; mh = 0; mv = 0; mlat = 2'd0; req_cnt = 0; full_frame = 0;
      exp_q.delete();
    end else begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("vga_blank", vga_blank, e[26]);
        chk("h_sync", h_sync, e[25]);
        chk("v_sync", v_sync, e[24]);
        chk("rgb", {red, green, blue}, e[23:0]);
      end
      chk("vga_clock", vga_clock, ((k % CD) >= CD / 2));
      if ((k % CD) != CD - 1) begin
        chk("pix_req_idle", pix_req, 1'b0);
        chk("frame_start_idle", frame_start, 1'b0);
      end else begin
        act = (mh < HA) && (mv < VA);
        if (mh == 0 && mv == 0) begin
          if (full_frame) chk("req_per_frame", req_cnt, HA * VA);
          full_frame = 1;
          req_cnt = 0;
          mlat = mode;
          frames++;
        end
        chk("frame_start", frame_start, (mh == 0 && mv == 0));
        chk("pix_req", pix_req, act);
        if (act) begin
          chk("pix_x", pix_x, mh);
          chk("pix_y", pix_y, mv);
        end
        hs_e = !(mh >= HA + HF && mh < HA + HF + HSW);
        vs_e = !(mv >= VA + VF && mv < VA + VF + VSW);
        exp_q.push_back({act, hs_e, vs_e, exp_rgb(mlat, mh, mv, highlight)});
        if (mh == HT - 1) begin
          mh = 0;
          mv = (mv == VT - 1) ? 0 : mv + 1;
        end else begin
          mh++;
        end
      end
      if (pix_req) req_cnt++;
      k++;
    end
  end

  task automatic wait_pos(input int f, input int v, input int h);
    int n = 0;
    while (!(frames == f && mv == v && mh == h) && n < LIMIT) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wait_in_budget", (n < LIMIT), 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rgb"}, {red, green, blue}, 24'h0);
    chk({tag, "_h_sync"}, h_sync, 1'b1);
    chk({tag, "_v_sync"}, v_sync, 1'b1);
    chk({tag, "_blank"}, vga_blank, 1'b0);
    chk({tag, "_pix_req"}, pix_req, 1'b0);
    chk({tag, "_frame_start"}, frame_start, 1'b0);
    chk({tag, "_vga_clock"}, vga_clock, 1'b0);
    chk({tag, "_pix_x"}, pix_x, 12'd0);
  endtask

  initial begin
    rst = 1'b1; mode = 2'd0; highlight = '0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("por");
    rst = 1'b0;
    // frame 1 external source, then bars with a highlight change mid-frame
    wait_pos(1, 2, 0); mode = 2'd1;
    wait_pos(2, 2, 0); highlight = 3'b010;
    wait_pos(2, 4, 5); mode = 2'd2;
    wait_pos(2, 5, 0); highlight = 3'b101;
    wait_pos(3, 1, 0); mode = 2'd3;
    wait_pos(4, 1, 0); mode = 2'd1; highlight = 3'b000;
    wait_pos(5, 5, 15);
    rst = 1'b1;
    #1 check_reset_outputs("mid_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    wait_pos(7, 0, 1);
    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
